// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file writeback port arbiter.
// Default data/address widths; wb_req_t is built from these.
package wb_arb_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef struct packed {
    logic                  we;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests with a kill-by-destination port.
// Kill clears the write bit of stored entries only; a same-cycle push is not affected.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  push_req,
  input  logic                     pop,
  input  logic                     kill,
  input  logic [DEF_REG_AW-1:0]    kill_rd,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && mem[i].rd == kill_rd) mem[i].we <= 1'b0;
      end
      // Later assignment wins, so the incoming entry keeps its write bit.
      if (push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and buffered multi-cycle results.
// Optional stall-cycle counter enabled by defining WB_ARB_PERF_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int FIFO_DEPTH = 2
`ifdef WB_ARB_PERF_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_data,
  output logic              pipe_stall,
  input  logic              mc_valid,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [XLEN-1:0]   mc_data,
  output logic              mc_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              busy
`ifdef WB_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stalls
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          pipe_req;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          kill;
  logic [CW-1:0] count;
  wb_req_t       head;
  wb_req_t       push_req;
  grant_e        grant;

  assign pipe_req = pipe_valid & pipe_we;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign mc_ready = !full;
  assign busy     = !empty;
  assign push     = mc_valid & mc_ready;
  assign pop      = (grant == GNT_FIFO);
  assign kill     = (grant == GNT_PIPE);
  assign push_req = '{we: 1'b1, rd: mc_rd, data: mc_data};

  // A full buffer must drain ahead of the pipeline, otherwise the unit could deadlock.
  always_comb begin
    grant      = GNT_NONE;
    pipe_stall = 1'b0;
    if (pipe_req && full) begin
      grant      = GNT_FIFO;
      pipe_stall = 1'b1;
    end else if (pipe_req) begin
      grant = GNT_PIPE;
    end else if (!empty) begin
      grant = GNT_FIFO;
    end
  end

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .kill     (kill),
    .kill_rd  (pipe_rd),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (grant)
        GNT_PIPE: begin
          rf_we    <= (pipe_rd != '0);
          rf_waddr <= pipe_rd;
          rf_wdata <= pipe_data;
        end
        GNT_FIFO: begin
          rf_we    <= head.we && (head.rd != '0);
          rf_waddr <= head.rd;
          rf_wdata <= head.data;
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               perf_stalls <= '0;
    else if (pipe_stall && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
  end
`endif

endmodule
